// File: rtl/retire_monitor.sv
`default_nettype none
//==============================================================================
// Module   : retire_monitor
// Purpose  : Registered monitor on the retire stream of a single-cycle core.
//            Re-times the retire stream by one cycle and counts retired
//            instructions and cycles. Detects end-of-program (the same PC
//            retired HALT_CNT times in a row), a retire watchdog timeout
//            (WDOG_CYCLES cycles in a row with no retire) and misaligned
//            retire PCs. On halt it snapshots the red-LED result word so the
//            scoreboard has one stable pass/fail source.
//
// Optional feature macro : RETIRE_HISTORY_EN
//   defined     -> 8-entry history of retired PCs, read via i_hist_idx
//   not defined -> no history storage, o_hist_pc reads 0
//
// Parameters:
//   HALT_CNT    : consecutive same-PC retires that declare halt (2..255)
//   WDOG_CYCLES : consecutive cycles without retire that declare timeout
//                 (1..2^20-1)
//
// Ports:
//   i_clk        in   1  clock, all state on rising edge
//   i_reset      in   1  asynchronous reset, active-low
//   i_pc_debug   in  32  PC of the instruction retiring this cycle
//   i_insn_vld   in   1  retire valid
//   i_io_ledr    in  32  core red-LED output (test result word)
//   i_hist_idx   in   3  history read index, 0 = newest
//   o_pc         out 32  registered retire PC (0 when not valid)
//   o_vld        out  1  registered retire valid
//   o_insn_cnt   out 32  retired instruction count (saturating)
//   o_cycle_cnt  out 32  cycle count while IDLE/RUN (saturating)
//   o_state      out  2  IDLE=0, RUN=1, HALTED=2, TIMEOUT=3
//   o_halt       out  1  state is HALTED
//   o_timeout    out  1  state is TIMEOUT
//   o_misalign   out  1  sticky: a retire had PC[1:0] != 0
//   o_ledr_snap  out 32  i_io_ledr captured on entry to HALTED
//   o_hist_pc    out 32  history entry i_hist_idx (combinational read)
//
// Revision : 1.0 - initial release
//==============================================================================
module retire_monitor #(
  parameter int unsigned HALT_CNT    = 4,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_debug,
  input  logic        i_insn_vld,
  input  logic [31:0] i_io_ledr,
  input  logic [2:0]  i_hist_idx,
  output logic [31:0] o_pc,
  output logic        o_vld,
  output logic [31:0] o_insn_cnt,
  output logic [31:0] o_cycle_cnt,
  output logic [1:0]  o_state,
  output logic        o_halt,
  output logic        o_timeout,
  output logic        o_misalign,
  output logic [31:0] o_ledr_snap,
  output logic [31:0] o_hist_pc
);

  //--------------------------------------------------------------------------
  // Constants
  //--------------------------------------------------------------------------
  localparam logic [1:0]  c_IDLE       = 2'd0;
  localparam logic [1:0]  c_RUN        = 2'd1;
  localparam logic [1:0]  c_HALTED     = 2'd2;
  localparam logic [1:0]  c_TIMEOUT    = 2'd3;

  // Thresholds resized to the width of the counters they are compared with.
  localparam logic [7:0]  c_HALT_CNT   = 8'(HALT_CNT);
  localparam logic [19:0] c_WDOG_LIMIT = 20'(WDOG_CYCLES);
  localparam logic [31:0] c_CNT_MAX    = 32'hFFFF_FFFF;

  //--------------------------------------------------------------------------
  // Declarations
  //--------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [1:0]  w_state_next;

  logic [31:0] r_pc;
  logic        r_vld;

  logic [31:0] r_insn_cnt;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_last_pc;
  logic [7:0]  r_rep_cnt;
  logic [19:0] r_wdog_cnt;
  logic        r_misalign;
  logic [31:0] r_ledr_snap;

  logic        w_active;
  logic        w_same_pc;
  logic [7:0]  w_rep_next;
  logic [19:0] w_wdog_next;
  logic        w_hit_halt;
  logic        w_hit_wdog;
  logic        w_enter_halt;
  logic        w_misaligned_retire;
  logic [31:0] w_insn_inc;
  logic [31:0] w_cycle_inc;

  //--------------------------------------------------------------------------
  // Detection datapath
  //--------------------------------------------------------------------------
  // Counting, tracking and history only advance in the non-terminal states.
  assign w_active = (r_state == c_IDLE) || (r_state == c_RUN);

  // r_last_pc holds nothing meaningful before the first retire, so a match is
  // only honoured once in RUN; the first retire always restarts the run at 1.
  assign w_same_pc  = (r_state == c_RUN) && (i_pc_debug == r_last_pc);
  assign w_rep_next = w_same_pc ? (r_rep_cnt + 8'd1) : 8'd1;

  // Halt fires on the retire that would bring the run length to HALT_CNT.
  // rep_cnt never passes HALT_CNT because reaching it is terminal.
  assign w_hit_halt = i_insn_vld && (w_rep_next == c_HALT_CNT);

  // The watchdog only advances on idle cycles. A retire clears it, which is
  // what keeps halt and timeout from ever firing on the same edge.
  assign w_wdog_next = r_wdog_cnt + 20'd1;
  assign w_hit_wdog  = !i_insn_vld && (w_wdog_next == c_WDOG_LIMIT);

  assign w_enter_halt = w_active && (w_state_next == c_HALTED);

  assign w_misaligned_retire = i_insn_vld && (i_pc_debug[1:0] != 2'b00);

  // Saturating increments: counters park at all-ones instead of wrapping.
  assign w_insn_inc  = (r_insn_cnt  != c_CNT_MAX) ? (r_insn_cnt  + 32'd1) : r_insn_cnt;
  assign w_cycle_inc = (r_cycle_cnt != c_CNT_MAX) ? (r_cycle_cnt + 32'd1) : r_cycle_cnt;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        // The first retire can never complete a run (HALT_CNT >= 2).
        if (i_insn_vld) begin
          w_state_next = c_RUN;
        end else if (w_hit_wdog) begin
          w_state_next = c_TIMEOUT;
        end
      end
      c_RUN: begin
        if (w_hit_halt) begin
          w_state_next = c_HALTED;
        end else if (w_hit_wdog) begin
          w_state_next = c_TIMEOUT;
        end
      end
      default: begin
        // HALTED and TIMEOUT hold until reset.
        w_state_next = r_state;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: output decode (from the registered state, so still registered)
  //--------------------------------------------------------------------------
  always_comb begin
    o_state   = r_state;
    o_halt    = (r_state == c_HALTED);
    o_timeout = (r_state == c_TIMEOUT);
  end

  //--------------------------------------------------------------------------
  // Retire pass-through: active in every state, including the terminal ones
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_vld <= 1'b0;
      r_pc  <= 32'd0;
    end else begin
      r_vld <= i_insn_vld;
      r_pc  <= i_insn_vld ? i_pc_debug : 32'd0;
    end
  end

  //--------------------------------------------------------------------------
  // Counters, halt/watchdog tracking, sticky flags and LED snapshot.
  // Everything here is frozen once a terminal state is reached.
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_insn_cnt  <= 32'd0;
      r_cycle_cnt <= 32'd0;
      r_last_pc   <= 32'd0;
      r_rep_cnt   <= 8'd0;
      r_wdog_cnt  <= 20'd0;
      r_misalign  <= 1'b0;
      r_ledr_snap <= 32'd0;
    end else if (w_active) begin
      r_cycle_cnt <= w_cycle_inc;

      if (i_insn_vld) begin
        r_insn_cnt <= w_insn_inc;
        r_last_pc  <= i_pc_debug;
        r_rep_cnt  <= w_rep_next;
        r_wdog_cnt <= 20'd0;
      end else begin
        r_wdog_cnt <= w_wdog_next;
      end

      if (w_misaligned_retire) begin
        r_misalign <= 1'b1;
      end

      // Captured on the same edge that enters HALTED; never on timeout.
      if (w_enter_halt) begin
        r_ledr_snap <= i_io_ledr;
      end
    end
  end

  assign o_pc        = r_pc;
  assign o_vld       = r_vld;
  assign o_insn_cnt  = r_insn_cnt;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_misalign  = r_misalign;
  assign o_ledr_snap = r_ledr_snap;

  //--------------------------------------------------------------------------
  // Retire history
  //--------------------------------------------------------------------------
`ifdef RETIRE_HISTORY_EN
  // Shift register: entry 0 is always the newest retire, so the read index
  // maps straight onto the storage with no pointer arithmetic. Entries that
  // have not been written yet still hold their reset value of 0.
  logic [7:0][31:0] r_hist;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_hist <= '0;
    end else if (w_active && i_insn_vld) begin
      r_hist <= {r_hist[6:0], i_pc_debug};
    end
  end

  assign o_hist_pc = r_hist[i_hist_idx];
`else
  // No storage is built. The index is folded in with a zero mask so the
  // port stays referenced; the result is a constant 0.
  assign o_hist_pc = 32'(i_hist_idx) & 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_retire_monitor.sv
`default_nettype none
//==============================================================================
// Module   : tb_retire_monitor
// Purpose  : Self-checking bench for retire_monitor. Directed scenarios plus
//            randomized retire streams compared cycle by cycle against a
//            behavioural model built from the monitor's rules (run lengths,
//            idle-cycle counts, a queue of retired PCs).
// Revision : 1.0 - initial release
//==============================================================================
module tb_retire_monitor;

  localparam int HALT_CNT    = 4;
  localparam int WDOG_CYCLES = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_in;
  logic        vld_in;
  logic [31:0] led_in;
  logic [2:0]  hidx;

  wire  [31:0] o_pc;
  wire         o_vld;
  wire  [31:0] o_insn_cnt;
  wire  [31:0] o_cycle_cnt;
  wire  [1:0]  o_state;
  wire         o_halt;
  wire         o_timeout;
  wire         o_misalign;
  wire  [31:0] o_ledr_snap;
  wire  [31:0] o_hist_pc;

  always #5 clk = ~clk;

  retire_monitor #(
    .HALT_CNT    (HALT_CNT),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset_n),
    .i_pc_debug  (pc_in),
    .i_insn_vld  (vld_in),
    .i_io_ledr   (led_in),
    .i_hist_idx  (hidx),
    .o_pc        (o_pc),
    .o_vld       (o_vld),
    .o_insn_cnt  (o_insn_cnt),
    .o_cycle_cnt (o_cycle_cnt),
    .o_state     (o_state),
    .o_halt      (o_halt),
    .o_timeout   (o_timeout),
    .o_misalign  (o_misalign),
    .o_ledr_snap (o_ledr_snap),
    .o_hist_pc   (o_hist_pc)
  );

  int n_cmp = 0;
  int n_err = 0;

  //--------------------------------------------------------------------------
  // Behavioural reference model
  //--------------------------------------------------------------------------
  bit              m_started;   // at least one retire seen since reset
  int              m_term;      // 0 = running, 1 = halted, 2 = timed out
  longint unsigned m_insn;
  longint unsigned m_cyc;
  logic [31:0]     m_last;
  int              m_run;       // length of the current same-PC retire run
  int              m_idle;      // invalid cycles since last retire/reset
  bit              m_mis;
  logic [31:0]     m_snap;
  logic [31:0]     m_opc;
  bit              m_ovld;
  logic [31:0]     m_hist[$];

  task automatic model_reset();
    m_started = 0; m_term = 0; m_insn = 0; m_cyc = 0; m_last = 0;
    m_run = 0; m_idle = 0; m_mis = 0; m_snap = 0; m_opc = 0; m_ovld = 0;
    m_hist.delete();
  endtask

  task automatic model_step(input bit vld, input logic [31:0] pc, input logic [31:0] led);
    m_ovld = vld;
    m_opc  = vld ? pc : 32'h0;
    if (m_term != 0) return;
    if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
    if (vld) begin
      if (m_insn < 64'hFFFF_FFFF) m_insn++;
      if (m_started && pc == m_last) m_run++;
      else m_run = 1;
      m_last = pc; m_started = 1; m_idle = 0;
      if (pc[1:0] != 2'b00) m_mis = 1;
      m_hist.push_front(pc);
      if (m_hist.size() > 8) void'(m_hist.pop_back());
      if (m_run == HALT_CNT) begin
        m_term = 1;
        m_snap = led;
      end
    end else begin
      m_idle++;
      if (m_idle == WDOG_CYCLES) m_term = 2;
    end
  endtask

  function automatic logic [1:0] model_state();
    if (m_term == 1) return 2'd2;
    if (m_term == 2) return 2'd3;
    return m_started ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [31:0] model_hist(input int idx);
`ifdef RETIRE_HISTORY_EN
    return (idx < m_hist.size()) ? m_hist[idx] : 32'h0;
`else
    return 32'h0;
`endif
  endfunction

  //--------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  //--------------------------------------------------------------------------
  // Drive one retire slot, let the edge sample it, advance the model and
  // return 1 ns after the edge so outputs are read away from it.
  task automatic cycle(input bit vld, input logic [31:0] pc);
    vld_in = vld;
    pc_in  = pc;
    @(posedge clk);
    model_step(vld, pc, led_in);
    #1;
  endtask

  task automatic do_reset();
    vld_in  = 1'b0;
    pc_in   = 32'h0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  //--------------------------------------------------------------------------
  // Scenarios
  //--------------------------------------------------------------------------
  task automatic test_reset();
    pc_in = 32'h1234_5677; vld_in = 1'b1; led_in = 32'hFF; hidx = 3'd0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (o_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", o_vld); end
    n_cmp++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", o_pc); end
    n_cmp++; if (o_insn_cnt !== 32'h0) begin n_err++; $display("FAIL reset_insn: got %0d want 0", o_insn_cnt); end
    n_cmp++; if (o_cycle_cnt !== 32'h0) begin n_err++; $display("FAIL reset_cycle: got %0d want 0", o_cycle_cnt); end
    n_cmp++; if (o_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", o_state); end
    n_cmp++; if (o_halt !== 1'b0 || o_timeout !== 1'b0) begin n_err++; $display("FAIL reset_flags: got halt=%b timeout=%b want 0/0", o_halt, o_timeout); end
    n_cmp++; if (o_misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", o_misalign); end
    n_cmp++; if (o_ledr_snap !== 32'h0) begin n_err++; $display("FAIL reset_snap: got %h want 0", o_ledr_snap); end
    for (int i = 0; i < 8; i++) begin
      hidx = 3'(i);
      #1;
      n_cmp++; if (o_hist_pc !== 32'h0) begin n_err++; $display("FAIL reset_hist[%0d]: got %h want 0", i, o_hist_pc); end
    end
    vld_in = 1'b0; pc_in = 32'h0; hidx = 3'd0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_timeout();
    // Follows test_reset directly: no retires at all after release.
    for (int i = 1; i <= WDOG_CYCLES; i++) begin
      cycle(1'b0, 32'h0);
      n_cmp++;
      if (o_timeout !== (i == WDOG_CYCLES)) begin
        n_err++; $display("FAIL timeout_edge[%0d]: got %b want %b", i, o_timeout, (i == WDOG_CYCLES));
      end
    end
    n_cmp++; if (o_state !== 2'd3) begin n_err++; $display("FAIL timeout_state: got %0d want 3", o_state); end
    n_cmp++; if (o_cycle_cnt !== 32'd16) begin n_err++; $display("FAIL timeout_cycle: got %0d want 16", o_cycle_cnt); end
    n_cmp++; if (o_insn_cnt !== 32'd0) begin n_err++; $display("FAIL timeout_insn: got %0d want 0", o_insn_cnt); end
    // Terminal: counters frozen, pass-through alive.
    cycle(1'b1, 32'h40);
    cycle(1'b1, 32'h44);
    n_cmp++; if (o_vld !== 1'b1 || o_pc !== 32'h44) begin n_err++; $display("FAIL timeout_passthru: got vld=%b pc=%h want 1/00000044", o_vld, o_pc); end
    n_cmp++; if (o_insn_cnt !== 32'd0 || o_cycle_cnt !== 32'd16) begin n_err++; $display("FAIL timeout_frozen: got insn=%0d cyc=%0d want 0/16", o_insn_cnt, o_cycle_cnt); end
    n_cmp++; if (o_state !== 2'd3) begin n_err++; $display("FAIL timeout_sticky: got %0d want 3", o_state); end
  endtask

  task automatic test_halt();
    logic [31:0] seq [7];
    seq = '{32'h0, 32'h4, 32'h8, 32'h1680, 32'h1680, 32'h1680, 32'h1680};
    led_in = 32'h1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, seq[i]);
      n_cmp++;
      if (o_halt !== (i == 6)) begin
        n_err++; $display("FAIL halt_edge[%0d]: got %b want %b", i, o_halt, (i == 6));
      end
    end
    n_cmp++; if (o_insn_cnt !== 32'd7) begin n_err++; $display("FAIL halt_insn: got %0d want 7", o_insn_cnt); end
    n_cmp++; if (o_ledr_snap !== 32'h1) begin n_err++; $display("FAIL halt_snap: got %h want 1", o_ledr_snap); end
    n_cmp++; if (o_state !== 2'd2) begin n_err++; $display("FAIL halt_state: got %0d want 2", o_state); end
    n_cmp++; if (o_cycle_cnt !== 32'd7) begin n_err++; $display("FAIL halt_cycle: got %0d want 7", o_cycle_cnt); end
    led_in = 32'h55;
    cycle(1'b1, 32'h2000);
    n_cmp++; if (o_vld !== 1'b1 || o_pc !== 32'h2000) begin n_err++; $display("FAIL halt_passthru: got vld=%b pc=%h want 1/00002000", o_vld, o_pc); end
    n_cmp++; if (o_insn_cnt !== 32'd7 || o_ledr_snap !== 32'h1) begin n_err++; $display("FAIL halt_frozen: got insn=%0d snap=%h want 7/1", o_insn_cnt, o_ledr_snap); end
    cycle(1'b0, 32'h2004);
    n_cmp++; if (o_vld !== 1'b0 || o_pc !== 32'h0) begin n_err++; $display("FAIL halt_passthru_idle: got vld=%b pc=%h want 0/0", o_vld, o_pc); end
  endtask

  task automatic test_broken_run();
    logic [31:0] seq [6];
    seq = '{32'h20, 32'h20, 32'h24, 32'h20, 32'h20, 32'h20};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, seq[i]);
      n_cmp++; if (o_halt !== 1'b0) begin n_err++; $display("FAIL broken_nohalt[%0d]: got %b want 0", i, o_halt); end
    end
    n_cmp++; if (o_state !== 2'd1) begin n_err++; $display("FAIL broken_state: got %0d want 1", o_state); end
    // Fourth consecutive 0x20 completes the run.
    cycle(1'b1, 32'h20);
    n_cmp++; if (o_halt !== 1'b1) begin n_err++; $display("FAIL broken_4th: got %b want 1", o_halt); end
  endtask

  task automatic test_misalign();
    do_reset();
    cycle(1'b1, 32'h100);
    n_cmp++; if (o_misalign !== 1'b0) begin n_err++; $display("FAIL misalign_clean: got %b want 0", o_misalign); end
    cycle(1'b1, 32'h102);
    n_cmp++; if (o_misalign !== 1'b1) begin n_err++; $display("FAIL misalign_set: got %b want 1", o_misalign); end
    n_cmp++; if (o_state !== 2'd1) begin n_err++; $display("FAIL misalign_state: got %0d want 1", o_state); end
    cycle(1'b1, 32'h104);
    n_cmp++; if (o_misalign !== 1'b1) begin n_err++; $display("FAIL misalign_sticky: got %b want 1", o_misalign); end
  endtask

  task automatic test_async_reset();
    led_in = 32'hA5;
    do_reset();
    cycle(1'b1, 32'h201);
    cycle(1'b1, 32'h204);
    cycle(1'b1, 32'h208);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (o_pc !== 32'h0 || o_vld !== 1'b0) begin n_err++; $display("FAIL async_passthru: got vld=%b pc=%h want 0/0", o_vld, o_pc); end
    n_cmp++; if (o_insn_cnt !== 32'h0 || o_cycle_cnt !== 32'h0) begin n_err++; $display("FAIL async_counts: got insn=%0d cyc=%0d want 0/0", o_insn_cnt, o_cycle_cnt); end
    n_cmp++; if (o_state !== 2'd0 || o_misalign !== 1'b0) begin n_err++; $display("FAIL async_state: got state=%0d mis=%b want 0/0", o_state, o_misalign); end
    vld_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 32'h0);
      n_cmp++; if (o_state !== 2'd0) begin n_err++; $display("FAIL async_idle[%0d]: got %0d want 0", i, o_state); end
    end
    n_cmp++; if (o_cycle_cnt !== 32'd3) begin n_err++; $display("FAIL async_restart_cycle: got %0d want 3", o_cycle_cnt); end
    cycle(1'b1, 32'h300);
    n_cmp++; if (o_state !== 2'd1 || o_insn_cnt !== 32'd1) begin n_err++; $display("FAIL async_rerun: got state=%0d insn=%0d want 1/1", o_state, o_insn_cnt); end
  endtask

  task automatic test_history();
    logic [31:0] exp_h [8];
`ifdef RETIRE_HISTORY_EN
    exp_h = '{32'h18, 32'h14, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`else
    exp_h = '{default: 32'h0};
`endif
    do_reset();
    cycle(1'b1, 32'h10);
    cycle(1'b1, 32'h14);
    cycle(1'b1, 32'h18);
    for (int i = 0; i < 8; i++) begin
      hidx = 3'(i);
      #1;
      n_cmp++; if (o_hist_pc !== exp_h[i]) begin n_err++; $display("FAIL hist[%0d]: got %h want %h", i, o_hist_pc, exp_h[i]); end
    end
    hidx = 3'd0;
  endtask

  task automatic test_random();
    int          pvld [4];
    logic [31:0] cur_pc;
    bit          v;
    pvld = '{95, 80, 50, 8};
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      cur_pc = 32'h1000;
      for (int c = 0; c < 250; c++) begin
        v = ($urandom_range(0, 99) < pvld[ep % 4]);
        if ($urandom_range(0, 2) != 0) begin
          cur_pc = 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
          if ($urandom_range(0, 19) == 0) cur_pc = cur_pc + 32'($urandom_range(1, 3));
        end
        led_in = $urandom();
        hidx   = 3'($urandom_range(0, 7));
        cycle(v, v ? cur_pc : $urandom());
        n_cmp++; if (o_vld !== m_ovld || o_pc !== m_opc) begin n_err++; $display("FAIL rand_passthru ep%0d c%0d: got vld=%b pc=%h want %b/%h", ep, c, o_vld, o_pc, m_ovld, m_opc); end
        n_cmp++; if (o_insn_cnt !== 32'(m_insn)) begin n_err++; $display("FAIL rand_insn ep%0d c%0d: got %0d want %0d", ep, c, o_insn_cnt, m_insn); end
        n_cmp++; if (o_cycle_cnt !== 32'(m_cyc)) begin n_err++; $display("FAIL rand_cycle ep%0d c%0d: got %0d want %0d", ep, c, o_cycle_cnt, m_cyc); end
        n_cmp++; if (o_state !== model_state()) begin n_err++; $display("FAIL rand_state ep%0d c%0d: got %0d want %0d", ep, c, o_state, model_state()); end
        n_cmp++; if (o_halt !== (m_term == 1) || o_timeout !== (m_term == 2)) begin n_err++; $display("FAIL rand_flags ep%0d c%0d: got halt=%b timeout=%b want term=%0d", ep, c, o_halt, o_timeout, m_term); end
        n_cmp++; if (o_misalign !== m_mis) begin n_err++; $display("FAIL rand_misalign ep%0d c%0d: got %b want %b", ep, c, o_misalign, m_mis); end
        n_cmp++; if (o_ledr_snap !== m_snap) begin n_err++; $display("FAIL rand_snap ep%0d c%0d: got %h want %h", ep, c, o_ledr_snap, m_snap); end
        n_cmp++; if (o_hist_pc !== model_hist(int'(hidx))) begin n_err++; $display("FAIL rand_hist ep%0d c%0d idx%0d: got %h want %h", ep, c, hidx, o_hist_pc, model_hist(int'(hidx))); end
        // Occasional asynchronous reset pulse between edges.
        if ($urandom_range(0, 199) == 0) begin
          #3;
          reset_n = 1'b0;
          model_reset();
          #1;
          n_cmp++; if (o_state !== 2'd0 || o_insn_cnt !== 32'h0 || o_cycle_cnt !== 32'h0 || o_vld !== 1'b0) begin n_err++; $display("FAIL rand_async ep%0d c%0d: got state=%0d insn=%0d cyc=%0d vld=%b want all 0", ep, c, o_state, o_insn_cnt, o_cycle_cnt, o_vld); end
          vld_in = 1'b0;
          @(posedge clk);
          @(negedge clk);
          reset_n = 1'b1;
        end
      end
    end
  endtask

  //--------------------------------------------------------------------------
  // Sequencer
  //--------------------------------------------------------------------------
  initial begin
    reset_n = 1'b0;
    vld_in  = 1'b0;
    pc_in   = 32'h0;
    led_in  = 32'h0;
    hidx    = 3'd0;
    test_reset();
    test_timeout();
    test_halt();
    test_broken_run();
    test_misalign();
    test_async_reset();
    test_history();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Time bound on the whole run.
  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got no finish want finish before 1ms");
    $fatal(1, "time limit expired");
  end

endmodule
`default_nettype wire

// File: doc/retire_monitor.md
# retire_monitor

Registered retire-stream monitor between the single-cycle RISC-V core's debug outputs (`o_pc_debug`, `o_insn_vld`, `o_io_ledr`) and the test scoreboard. It re-times the retire stream by one cycle and counts retired instructions and cycles. It detects end-of-program (a PC self-loop), a retire watchdog timeout and misaligned PCs. At halt it snapshots the red-LED result word so the bench has a single, stable pass/fail source.

## Interface
Parameters:
- `HALT_CNT`, 4: consecutive valid retires at the same PC that declare halt; legal range 2..255.
- `WDOG_CYCLES`, 1024: consecutive cycles without a valid retire that declare timeout; legal range 1..2^20-1.

Ports:
- `i_clk` input 1: clock, all state on rising edge.
- `i_reset` input 1: reset, asynchronous assert, active-low (0 = reset).
- `i_pc_debug` input 32: PC of the instruction retiring this cycle.
- `i_insn_vld` input 1: retire valid.
- `i_io_ledr` input 32: core red-LED output (test result word).
- `o_pc` output 32: registered `i_pc_debug`; 0 if the sampled valid was 0.
- `o_vld` output 1: registered `i_insn_vld`.
- `o_insn_cnt` output 32: valid retires counted.
- `o_cycle_cnt` output 32: cycles counted.
- `o_state` output 2: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
- `o_halt` output 1: state == HALTED.
- `o_timeout` output 1: state == TIMEOUT.
- `o_misalign` output 1: sticky; a valid retire had PC[1:0] != 0.
- `o_ledr_snap` output 32: `i_io_ledr` captured on entry to HALTED.
- `i_hist_idx` input 3: history read index (0 = newest).
- `o_hist_pc` output 32: history entry (see Configuration).

## Operation
- Reset (`i_reset`=0): all outputs, counters, history and internal `last_pc`/`rep_cnt`/`wdog_cnt` go to 0. State goes to IDLE.
- Retire pass-through: `o_vld`/`o_pc` update every cycle in all states, including the terminal states.
- IDLE -> RUN on the first valid retire. That retire is counted, loads `last_pc` and sets `rep_cnt`=1.
- In IDLE/RUN:
  - `o_cycle_cnt` increments every cycle.
  - `o_insn_cnt` increments per valid retire.
  - Both saturate at 0xFFFF_FFFF.
- Halt detection (IDLE/RUN):
  - A valid retire with PC == `last_pc` increments `rep_cnt`.
  - A valid retire with a different PC sets `rep_cnt`=1 and `last_pc`=PC.
  - Invalid cycles leave `rep_cnt`/`last_pc` unchanged.
  - When `rep_cnt` would reach `HALT_CNT`: go to HALTED and capture `o_ledr_snap` = `i_io_ledr` at that same edge.
- Watchdog (IDLE/RUN):
  - `wdog_cnt` clears on a valid retire and otherwise increments.
  - When it would reach `WDOG_CYCLES`: go to TIMEOUT. `o_ledr_snap` is not updated.
- Priority: a valid retire clears the watchdog, so halt and timeout can never fire on the same edge.
- HALTED and TIMEOUT are terminal until reset.
  - Counters, `o_ledr_snap`, `o_misalign` and history are frozen.
  - Pass-through stays active.
- `o_misalign` sets on any valid retire with PC[1:0] != 0, in any state except terminal. It does not change state.
- Reset asserted mid-run returns everything to reset values asynchronously. Counting restarts at the first edge after release.

## Timing
- All outputs are registered, with one-cycle latency from inputs.
  - `o_pc`/`o_vld` show the retire sampled at the previous edge.
  - `o_halt` goes high at the edge that samples the `HALT_CNT`-th matching retire.
- `o_cycle_cnt` reads N after N edges in IDLE/RUN since reset release.
- `o_timeout` rises at the edge where the `WDOG_CYCLES`-th consecutive invalid cycle is sampled.
- `o_hist_pc` is combinational from `i_hist_idx` over registered history (zero-cycle read).

## Configuration
- `RETIRE_HISTORY_EN` defined:
  - An 8-entry ring buffer records the PC of every valid retire in IDLE/RUN.
  - The newest entry is at index 0, and entries not yet written read 0.
  - The buffer is frozen in the terminal states.
  - `o_hist_pc` returns entry `i_hist_idx`.
- Not defined: no buffer is built and `o_hist_pc` is tied to 0.

## Test plan
- Reset held 3 cycles, then released with no valid retires and `WDOG_CYCLES`=16:
  - after the 16th invalid cycle, `o_timeout`=1 and `o_state`=3;
  - `o_cycle_cnt`=16, `o_insn_cnt`=0.
- Retire PC 0x0,0x4,0x8, then 0x1680 four times with `i_io_ledr`=0x1 and `HALT_CNT`=4:
  - `o_halt`=1 at the 7th retire edge;
  - `o_insn_cnt`=7, `o_ledr_snap`=0x1;
  - further retires leave `o_insn_cnt`=7 while `o_vld`/`o_pc` keep tracking.
- Retire 0x20,0x20,0x24,0x20,0x20,0x20 with `HALT_CNT`=4: no halt, because the run was broken by 0x24.
- Valid retire PC=0x102 in RUN: `o_misalign`=1 one cycle later, `o_state` stays 1.
- Pull `i_reset` low mid-RUN, asynchronously between edges:
  - all outputs are 0 immediately;
  - after release, `o_state`=0 until the next valid retire.
- With `RETIRE_HISTORY_EN`, retire 0x10,0x14,0x18:
  - idx0=0x18, idx1=0x14, idx2=0x10, idx3=0;
  - without the macro, every idx reads 0.
